// File: rtl/la_fsm.sv
// la_fsm: logic analyzer capture sequencer driving sample_mem, with register-bus slave.
// Define LA_TRIGGER_COUNT_EN to build the saturating trigger counter at +4.
module la_fsm #(
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned SAMPLE_DEPTH = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            trigger,
   input  logic [$clog2(SAMPLE_DEPTH):0]   size,
   output logic                            acquire,
   output logic                            pop,
   output logic                            clear,
   input  logic [15:0]                     addr_i,
   input  logic [15:0]                     wdata_i,
   input  logic [15:0]                     rdata_i,
   input  logic                            rw_i,
   input  logic                            valid_i,
   output logic [15:0]                     addr_o,
   output logic [15:0]                     wdata_o,
   output logic [15:0]                     rdata_o,
   output logic                            rw_o,
   output logic                            valid_o
);

   localparam int LW = $clog2(SAMPLE_DEPTH);
   localparam int SW = LW + 1;
   localparam logic [15:0]   MAX_LOC = 16'(SAMPLE_DEPTH - 1);
   localparam logic [SW-1:0] FULL    = SW'(SAMPLE_DEPTH);
`ifdef LA_TRIGGER_COUNT_EN
   localparam logic [15:0]   NREG    = 16'd5;
`else
   localparam logic [15:0]   NREG    = 16'd4;
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MOVE    = 3'd1,
      IN_POS  = 3'd2,
      CAPT    = 3'd3,
      CAPTD   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   tloc_q, tloc_d;
   logic            start_q, start_d, start_p_q;
   logic            stop_q, stop_d, stop_p_q;
   logic            clear_q, clear_d;
   logic            start_edge, stop_edge;
   logic [15:0]     off, rd_val;
   logic            hit, wr, rd;
`ifdef LA_TRIGGER_COUNT_EN
   logic [15:0]     cnt_q;
`endif

   assign off        = addr_i - 16'(BASE_ADDR);
   assign hit        = valid_i && (off < NREG);
   assign wr         = hit && rw_i;
   assign rd         = hit && !rw_i;
   assign start_edge = start_q && !start_p_q;
   assign stop_edge  = stop_q && !stop_p_q;
   assign clear      = clear_q;

   always_comb begin
      rd_val = '0;
      case (off)
         16'd0:   rd_val = {13'd0, state_q};
         16'd1:   rd_val = 16'(tloc_q);
         16'd2:   rd_val = {15'd0, start_q};
         16'd3:   rd_val = {15'd0, stop_q};
`ifdef LA_TRIGGER_COUNT_EN
         16'd4:   rd_val = cnt_q;
`endif
         default: rd_val = '0;
      endcase
   end

   // Clear fires in the last IDLE cycle so MOVE starts from an empty buffer.
   always_comb begin
      tloc_d  = tloc_q;
      start_d = start_q;
      stop_d  = stop_q;
      clear_d = 1'b0;
      if (wr && off == 16'd1 && state_q == IDLE)
         tloc_d = (wdata_i > MAX_LOC) ? MAX_LOC[LW-1:0] : wdata_i[LW-1:0];
      if (wr && off == 16'd2) begin
         start_d = wdata_i[0];
         clear_d = wdata_i[0] && !start_q && state_q == IDLE;
      end
      if (wr && off == 16'd3)
         stop_d = wdata_i[0];
   end

   always_comb begin
      state_d = state_q;
      acquire = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: if (start_edge) state_d = MOVE;
         MOVE: begin
            acquire = (size != {1'b0, tloc_q});
            if (size == {1'b0, tloc_q}) state_d = IN_POS;
         end
         IN_POS: begin
            acquire = 1'b1;
            pop     = !trigger;
            if (trigger) state_d = CAPT;
         end
         CAPT: begin
            acquire = (size < FULL);
            if (size == FULL) state_d = CAPTD;
         end
         CAPTD:   state_d = CAPTD;
         default: state_d = IDLE;
      endcase
      if (stop_edge) begin
         state_d = IDLE;
         acquire = 1'b0;
         pop     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tloc_q    <= '0;
         start_q   <= 1'b0;
         start_p_q <= 1'b0;
         stop_q    <= 1'b0;
         stop_p_q  <= 1'b0;
         clear_q   <= 1'b0;
         addr_o    <= '0;
         wdata_o   <= '0;
         rdata_o   <= '0;
         rw_o      <= 1'b0;
         valid_o   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tloc_q    <= tloc_d;
         start_q   <= start_d;
         start_p_q <= start_q;
         stop_q    <= stop_d;
         stop_p_q  <= stop_q;
         clear_q   <= clear_d;
         addr_o    <= addr_i;
         wdata_o   <= wdata_i;
         rdata_o   <= rd ? rd_val : rdata_i;
         rw_o      <= rw_i;
         valid_o   <= valid_i;
      end
   end

`ifdef LA_TRIGGER_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clear_q)
         cnt_q <= '0;
      else if (trigger && (state_q == IN_POS || state_q == CAPT)
               && cnt_q != 16'hFFFF)
         cnt_q <= cnt_q + 16'd1;
   end
`endif

endmodule
